fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Instruction-fetch front end that sits directly upstream of `decode`, in place of the bare `fetch` stage. It owns the PC and issues sequential reads to a one-cycle-latency instruction memory. Returned words are buffered with their PC+4 in a small prefetch FIFO, and the FIFO head is presented to `decode` under a stall/valid handshake. A taken-branch redirect from the memory stage (`pcSrc`, `pc_branched`) flushes the FIFO and any in-flight read.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; word-aligned.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out 32: read address; equals the internal PC register.
- `imem_rdata` in 32: instruction word; valid exactly one cycle after a cycle with `imem_req`=1.
- `pcSrc` in 1: redirect/flush strobe from the memory stage.
- `pc_branched` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `stall` in 1: `decode` cannot accept this cycle.
- `instr_valid` out 1: FIFO head is valid.
- `instruction` out 32: FIFO head instruction; 0 when empty.
- `pc_out` out 32: FIFO head PC+4, the same meaning as `pc_out_fetch`; 0 when empty.
- `flush_count` out 16: performance counter (see Configuration).
- `bubble_count` out 16: performance counter (see Configuration).

## Operation
- **State:**
  - `pc` register.
  - FIFO storage, read pointer, write pointer, and `count` (0..DEPTH).
  - `inflight` flag plus `inflight_pc`.
- **Reset (async):**
  - `pc`=RESET_PC; FIFO empty; `inflight`=0.
  - `instr_valid`=0, `instruction`=0, `pc_out`=0, counters=0.
  - `imem_req`=0 while `reset` is high.
- **Request:** `imem_req` = !reset && !pcSrc && (count + inflight < DEPTH).
  - This credit rule guarantees that every response has a free slot.
  - On request: `inflight`<=1, `inflight_pc`<=pc, `pc`<=pc+4 (32-bit wrap: FFFF_FFFC → 0000_0000).
- **Response:** when `inflight`=1 and `pcSrc`=0, push {`imem_rdata`, `inflight_pc`+4}. `inflight` clears unless a new request issues in the same cycle.
- **Pop:** occurs when `instr_valid` && !`stall`. The head advances, and push and pop may occur in the same cycle.
- **Flush:** `pcSrc`=1 takes priority over everything else.
  - `pc`<={pc_branched[31:2],2'b00}.
  - FIFO is emptied (pointers and `count` zeroed).
  - `inflight` is cleared and any response arriving that cycle is discarded.
  - No request and no pop are performed that cycle.
  - Flush applies regardless of `stall`.
- Pointers wrap modulo DEPTH. `count` is never above DEPTH and never below 0. A push while full is impossible by construction; the bench asserts this.
- Outputs `instruction`/`pc_out` are driven combinationally from the head entry, gated to 0 when `count`=0.

## Timing
- Steady state: one request per cycle while credits allow. Throughput is 1 instruction per cycle when `stall`=0.
- Request in cycle N → entry pushed at the end of N+1 → `instr_valid` visible in N+2.
- Redirect: `pcSrc` in cycle R → `imem_req` with `imem_addr`=target in R+1 → target instruction at head in R+3.
- From reset release in cycle 0: first request in cycle 0 (addr RESET_PC), first `instr_valid` in cycle 2.
- With `stall` held, the FIFO fills to DEPTH and `imem_req` drops. Once `count`+`inflight`=DEPTH, no further requests issue.
- A stall release at cycle S pops in S. A new request issues in S+1, when `count` drops below DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately, and any pending response is ignored.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `flush_count` increments on every cycle with `pcSrc`=1.
  - `bubble_count` increments on every cycle with `instr_valid`=0 && `stall`=0 && `reset`=0.
  - Both saturate at 16'hFFFF and clear on reset.
- `FETCH_PERF_CNT_EN` undefined: both ports are tied to 16'h0000 and no counter flops are synthesized.

## Test plan
- **Reset/stream:** release reset, `stall`=0, imem returns addr-derived words. Require:
  - `instr_valid` rises in cycle 2.
  - `pc_out` sequence is 4, 8, 12, … and `instruction` matches addresses 0, 4, 8.
- **Stall fill (DEPTH=4):** hold `stall` from cycle 0. Require:
  - Exactly 4 requests (addrs 0, 4, 8, C), then `imem_req`=0.
  - `count`=4 and the head stays at `pc_out`=4.
  - On release, 4 back-to-back pops precede new data from addr 10.
- **Redirect:** pulse `pcSrc` with `pc_branched`=32'h0000_0103 while the FIFO holds 3 entries and a read is in flight. Require:
  - `instr_valid`=0 next cycle.
  - `imem_addr`=32'h0000_0100 in R+1.
  - Head `pc_out`=32'h0000_0104 in R+3; no stale word is ever popped.
- **Flush vs. stall/pop:** assert `pcSrc` while `stall`=0 and the head is valid. Require that no pop is counted and the FIFO is empty the next cycle.
- **Wrap:** redirect to 32'hFFFF_FFF8. Require `imem_addr` FFFF_FFF8, FFFF_FFFC, 0000_0000, with `pc_out` FFFF_FFFC, 0000_0000, 0000_0004.
- **Counters (`FETCH_PERF_CNT_EN`):** 3 redirects plus reset. Require:
  - `flush_count`=3.
  - `bubble_count`=2 after the initial fill.
  - Both are 0 after a mid-run reset pulse.
  - Without the macro, both read 0 throughout.

Source files
------------

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: owns the PC, issues sequential imem reads and buffers
// returned words with PC+4 in a prefetch FIFO feeding decode.
// Optional counters: define FETCH_PERF_CNT_EN for flush/bubble counts.
module fetch_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        pcSrc,
   input  logic [31:0] pc_branched,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic [15:0] flush_count,
   output logic [15:0] bubble_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] L_DEPTH = DEPTH[CW:0];

   logic [31:0]   r_pc;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_instr_mem [DEPTH];
   logic [31:0]   r_pc_mem    [DEPTH];

   logic [CW:0]   w_used;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_target;

   // outstanding credits: buffered entries plus the read still in flight
   assign w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_target = pc_branched & ~32'h3;

   assign imem_req  = !reset && !pcSrc && (w_used < L_DEPTH);
   assign imem_addr = r_pc;

   // a flush discards the returning word and suppresses the pop
   assign w_push = r_inflight && !pcSrc;
   assign w_pop  = instr_valid && !stall && !pcSrc;

   assign instr_valid = (r_count != '0);
   assign instruction = instr_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
   assign pc_out      = instr_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;

   // PC, in-flight tracking and FIFO pointers/occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= 32'h0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else if (pcSrc) begin
         r_pc       <= w_target;
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= imem_req;
         if (imem_req) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // FIFO storage: instruction word and its PC+4
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= imem_rdata;
         r_pc_mem[r_wr_ptr]    <= r_inflight_pc + 32'd4;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_flush_cnt;
   logic [15:0] r_bubble_cnt;

   // saturating redirect and decode-starvation counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flush_cnt  <= 16'h0;
         r_bubble_cnt <= 16'h0;
      end else begin
         if (pcSrc && r_flush_cnt != 16'hFFFF) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
         if (!instr_valid && !stall && r_bubble_cnt != 16'hFFFF) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
         end
      end
   end

   assign flush_count  = r_flush_cnt;
   assign bubble_count = r_bubble_cnt;
`else
   assign flush_count  = 16'h0;
   assign bubble_count = 16'h0;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: randomized + directed bench for fetch_prefetch with
// an instruction-stream scoreboard and a request-credit reference model.
module tb_fetch_prefetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        pcSrc = 1'b0;
   logic [31:0] pc_branched = 32'h0;
   logic        stall = 1'b0;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic [15:0] flush_count;
   logic [15:0] bubble_count;

   int n_chk  = 0;
   int n_fail = 0;

   // expected popped stream {instruction, pc+4}, restarted on reset/redirect
   logic [63:0] exp_q[$];
   logic [31:0] gen_addr = RESET_PC;

   // reference model: cycle stamps of unpopped requests since last flush
   int          pend_q[$];
   int          cyc_n = 0;
   logic [31:0] m_req_addr = RESET_PC;
   logic [15:0] m_flush = 16'h0;
   logic [15:0] m_bub = 16'h0;

   fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .pcSrc(pcSrc),
      .pc_branched(pc_branched),
      .stall(stall),
      .instr_valid(instr_valid),
      .instruction(instruction),
      .pc_out(pc_out),
      .flush_count(flush_count),
      .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
   endfunction

   // one-cycle-latency instruction memory
   always @(posedge clk) begin
      imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic extend();
      exp_q.push_back({word_of(gen_addr), gen_addr + 32'd4});
      gen_addr = gen_addr + 32'd4;
   endtask

   // start a new cycle and drive its inputs
   task automatic step(input bit st, input bit ps,
                       input logic [31:0] tgt, input bit rs);
      @(posedge clk);
      #1;
      stall       = st;
      pcSrc       = ps;
      pc_branched = tgt;
      reset       = rs;
      if (rs) begin
         exp_q.delete();
         gen_addr = RESET_PC;
      end else begin
         if (ps) begin
            exp_q.delete();
            gen_addr = tgt & ~32'h3;
         end
         extend();
      end
   endtask

   // monitor: checks handshake, request credits, popped data and counters
   always @(negedge clk) begin
      bit          v_exp;
      bit          r_exp;
      logic [63:0] e;
      cyc_n++;
      if (reset) begin
         chkb("rst_req", imem_req, 1'b0);
         chkb("rst_valid", instr_valid, 1'b0);
         chk("rst_instr", instruction, 32'h0);
         chk("rst_pc_out", pc_out, 32'h0);
         chk("rst_flush_cnt", 32'(flush_count), 32'h0);
         chk("rst_bubble_cnt", 32'(bubble_count), 32'h0);
         pend_q.delete();
         m_req_addr = RESET_PC;
         m_flush    = 16'h0;
         m_bub      = 16'h0;
      end else begin
         v_exp = (pend_q.size() > 0) && (pend_q[0] <= cyc_n - 2);
         r_exp = !pcSrc && (pend_q.size() < DEPTH);
         chkb("valid", instr_valid, v_exp);
         chkb("req", imem_req, r_exp);
         if (r_exp && imem_req) begin
            chk("req_addr", imem_addr, m_req_addr);
         end
         chk("flush_count", 32'(flush_count), PERF ? 32'(m_flush) : 32'h0);
         chk("bubble_count", 32'(bubble_count), PERF ? 32'(m_bub) : 32'h0);
         if (!instr_valid) begin
            chk("empty_instr", instruction, 32'h0);
            chk("empty_pc_out", pc_out, 32'h0);
         end
         if (m_flush != 16'hFFFF && pcSrc) m_flush = m_flush + 16'd1;
         if (m_bub != 16'hFFFF && !v_exp && !stall) m_bub = m_bub + 16'd1;
         if (pcSrc) begin
            pend_q.delete();
            m_req_addr = pc_branched & ~32'h3;
         end else begin
            if (v_exp && !stall) begin
               void'(pend_q.pop_front());
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL pop_underflow: got pop expected none");
               end else begin
                  e = exp_q.pop_front();
                  chk("pop_instr", instruction, e[63:32]);
                  chk("pop_pc_out", pc_out, e[31:0]);
               end
            end
            if (r_exp) begin
               pend_q.push_back(cyc_n);
               m_req_addr = m_req_addr + 32'd4;
            end
         end
      end
   end

   initial begin
      logic [31:0] addrs[$];

      // reset and sequential stream
      repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("c0_valid", instr_valid, 1'b0);
      chkb("c0_req", imem_req, 1'b1);
      chk("c0_addr", imem_addr, RESET_PC);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("c1_valid", instr_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("c2_valid", instr_valid, 1'b1);
      chk("c2_pc_out", pc_out, RESET_PC + 32'd4);
      chk("c2_instr", instruction, word_of(RESET_PC));
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("bubble_after_fill", 32'(bubble_count), PERF ? 32'd2 : 32'd0);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);

      // redirect with 3 buffered entries and one read in flight
      repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
      @(negedge clk);
      chkb("r_valid", instr_valid, 1'b1);
      chkb("r_req", imem_req, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("r1_valid", instr_valid, 1'b0);
      chkb("r1_req", imem_req, 1'b1);
      chk("r1_addr", imem_addr, 32'h0000_0100);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("r2_valid", instr_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("r3_valid", instr_valid, 1'b1);
      chk("r3_pc_out", pc_out, 32'h0000_0104);
      chk("r3_instr", instruction, word_of(32'h0000_0100));

      // flush while the head would otherwise pop
      step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
      @(negedge clk);
      chkb("fp_valid", instr_valid, 1'b1);
      chkb("fp_req", imem_req, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("fp1_valid", instr_valid, 1'b0);
      chk("fp1_pc_out", pc_out, 32'h0);
      chk("fp1_addr", imem_addr, 32'h0000_0200);
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

      // PC wrap-around
      step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w1_addr", imem_addr, 32'hFFFF_FFF8);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w2_addr", imem_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w3_addr", imem_addr, 32'h0000_0000);
      chk("w3_pc_out", pc_out, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w4_pc_out", pc_out, 32'h0000_0000);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w5_pc_out", pc_out, 32'h0000_0004);
      chk("flush_three", 32'(flush_count), PERF ? 32'd3 : 32'd0);

      // mid-run reset pulse
      step(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("mr_flush_cnt", 32'(flush_count), 32'h0);
      chk("mr_bubble_cnt", 32'(bubble_count), 32'h0);
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);

      // stall fill to DEPTH, then release
      repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (imem_req) addrs.push_back(imem_addr);
         step(1'b1, 1'b0, 32'h0, 1'b0);
      end
      chk("fill_nreq", 32'(addrs.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("fill_addr", (k < addrs.size()) ? addrs[k] : 32'hFFFF_FFFF,
             32'(4 * k));
      end
      @(negedge clk);
      chkb("full_req", imem_req, 1'b0);
      chkb("full_valid", instr_valid, 1'b1);
      chk("full_pc_out", pc_out, 32'h4);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("s0_pc_out", pc_out, 32'h4);
      chkb("s0_req", imem_req, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chkb("s1_req", imem_req, 1'b1);
      chk("s1_addr", imem_addr, 32'h10);
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("s4_pc_out", pc_out, 32'h14);
      chk("s4_instr", instruction, word_of(32'h10));

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         step(($urandom % 10) < 3, ($urandom % 24) == 0, $urandom,
              ($urandom % 250) == 0);
      end
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
